// File: rtl/sram64kb_ctrl.sv
// Single-outstanding byte request controller for a banked SRAM array.
// Sequences bank select, output enable, write enable and the CE strobe, then returns one response per request.
module sram64kb_ctrl #(
    parameter int BANKS   = 128,
    parameter int ROW_AW  = 9,
    parameter int DW      = 8,
    parameter int RD_WAIT = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              REQ_VALID,
    output logic                              REQ_READY,
    input  logic                              REQ_WE,
    input  logic [ROW_AW+$clog2(BANKS)-1:0]   REQ_ADDR,
    input  logic [DW-1:0]                     REQ_WDATA,
    output logic                              RSP_VALID,
    output logic                              RSP_WE,
    output logic [DW-1:0]                     RSP_RDATA,
    output logic [ROW_AW-1:0]                 MEM_ADDR,
    output logic                              MEM_CE,
    output logic                              MEM_WEB,
    output logic [BANKS-1:0]                  MEM_OEB,
    output logic [BANKS-1:0]                  MEM_CSB,
    output logic [DW-1:0]                     MEM_IDATA,
    input  logic [DW-1:0]                     MEM_ODATA
);

    localparam int BW = $clog2(BANKS);
    localparam int AW = ROW_AW + BW;
    localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RWAIT,
        WREC,
        DONE
    } state_e;

    state_e             state_q;
    logic               we_q;
    logic [BW-1:0]      bank_q;
    logic [2:0]         wait_q;
    logic [ROW_AW-1:0]  mem_addr_q;
    logic [BANKS-1:0]   csb_q;
    logic [BANKS-1:0]   oeb_q;
    logic               web_q;
    logic               ce_q;
    logic [DW-1:0]      idata_q;
    logic               rsp_valid_q;
    logic               rsp_we_q;
    logic [DW-1:0]      rdata_q;

    function automatic logic [BANKS-1:0] bank_low(input logic [BW-1:0] b);
        logic [BANKS-1:0] m;
        m    = '1;
        m[b] = 1'b0;
        return m;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            bank_q      <= '0;
            wait_q      <= '0;
            mem_addr_q  <= '0;
            csb_q       <= '1;
            oeb_q       <= '1;
            web_q       <= 1'b1;
            ce_q        <= 1'b0;
            idata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ce_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ_VALID) begin
                        we_q       <= REQ_WE;
                        bank_q     <= REQ_ADDR[AW-1:ROW_AW];
                        mem_addr_q <= REQ_ADDR[ROW_AW-1:0];
                        csb_q      <= bank_low(REQ_ADDR[AW-1:ROW_AW]);
                        oeb_q      <= '1;
                        web_q      <= ~REQ_WE;
                        if (REQ_WE) begin
                            idata_q <= REQ_WDATA;
                        end
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    ce_q <= 1'b1;
                    if (!we_q) begin
                        oeb_q <= bank_low(bank_q);
                    end
                    state_q <= STROBE;
                end
                STROBE: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= we_q ? WREC : RWAIT;
                end
                RWAIT: begin
                    // Read data is sampled on the edge that closes the final wait cycle.
                    if (wait_q == 3'd0) begin
                        rdata_q     <= MEM_ODATA;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= we_q;
                        csb_q       <= '1;
                        oeb_q       <= '1;
                        web_q       <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                WREC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= we_q;
                    csb_q       <= '1;
                    oeb_q       <= '1;
                    web_q       <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = (state_q == IDLE) & ~RST;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_WE    = rsp_we_q;
    assign RSP_RDATA = rdata_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_CE    = ce_q;
    assign MEM_WEB   = web_q;
    assign MEM_OEB   = oeb_q;
    assign MEM_CSB   = csb_q;
    assign MEM_IDATA = idata_q;

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Bench for sram64kb_ctrl: behavioural banked array, vector table, scoreboard queue of expected responses.
// A second instance with RD_WAIT=3 shares the array to check the longer read wait.
module tb_sram64kb_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST;

    logic         req_valid, req_ready, req_we;
    logic [15:0]  req_addr;
    logic [7:0]   req_wdata;
    logic         rsp_valid, rsp_we;
    logic [7:0]   rsp_rdata;
    logic [8:0]   mem_addr;
    logic         mem_ce, mem_web;
    logic [127:0] mem_oeb, mem_csb;
    logic [7:0]   mem_idata, mem_odata;

    logic         req_valid3, req_ready3, req_we3;
    logic [15:0]  req_addr3;
    logic [7:0]   req_wdata3;
    logic         rsp_valid3, rsp_we3;
    logic [7:0]   rsp_rdata3;
    logic [8:0]   mem_addr3;
    logic         mem_ce3, mem_web3;
    logic [127:0] mem_oeb3, mem_csb3;
    logic [7:0]   mem_idata3, mem_odata3;

    sram64kb_ctrl dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_WE(rsp_we), .RSP_RDATA(rsp_rdata),
        .MEM_ADDR(mem_addr), .MEM_CE(mem_ce), .MEM_WEB(mem_web),
        .MEM_OEB(mem_oeb), .MEM_CSB(mem_csb),
        .MEM_IDATA(mem_idata), .MEM_ODATA(mem_odata)
    );

    sram64kb_ctrl #(.RD_WAIT(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(req_valid3), .REQ_READY(req_ready3), .REQ_WE(req_we3),
        .REQ_ADDR(req_addr3), .REQ_WDATA(req_wdata3),
        .RSP_VALID(rsp_valid3), .RSP_WE(rsp_we3), .RSP_RDATA(rsp_rdata3),
        .MEM_ADDR(mem_addr3), .MEM_CE(mem_ce3), .MEM_WEB(mem_web3),
        .MEM_OEB(mem_oeb3), .MEM_CSB(mem_csb3),
        .MEM_IDATA(mem_idata3), .MEM_ODATA(mem_odata3)
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Behavioural array: 128 banks x 512 bytes, preloaded with pat(), OR-combined read data.
    logic [7:0] mem [0:65535];
    logic       mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
            mem_init <= 1'b1;
        end else begin
            for (int b = 0; b < 128; b++) begin
                if (mem_ce && !mem_web && !mem_csb[b]) mem[{7'(b), mem_addr}] <= mem_idata;
                if (mem_ce3 && !mem_web3 && !mem_csb3[b]) mem[{7'(b), mem_addr3}] <= mem_idata3;
            end
        end
    end

    always_comb begin
        mem_odata = '0;
        for (int b = 0; b < 128; b++)
            if (!mem_csb[b] && !mem_oeb[b]) mem_odata = mem_odata | mem[{7'(b), mem_addr}];
    end

    always_comb begin
        mem_odata3 = '0;
        for (int b = 0; b < 128; b++)
            if (!mem_csb3[b] && !mem_oeb3[b]) mem_odata3 = mem_odata3 | mem[{7'(b), mem_addr3}];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] rdata;
        int         acc;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] ref_mem [0:65535];
    int         ce_cnt = 0;
    logic [7:0] last_rd = 8'h00;

    // Monitor: invariants every cycle, scoreboard pop on each response.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            ce_cnt  = 0;
            last_rd = 8'h00;
        end else begin
            if (mem_ce) ce_cnt++;
            chk("inv_csb_onehot", 128'($countones(~mem_csb) <= 1), 128'd1);
            chk("inv_oeb_on_csb", 128'(((~mem_oeb) & mem_csb) == '0 && $countones(~mem_oeb) <= 1), 128'd1);
            chk("inv_web_oeb", 128'(!(!mem_web && mem_oeb != '1)), 128'd1);
            if (rsp_valid) begin
                chk("rsp_has_pending_req", 128'(sbq.size() > 0), 128'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rsp_we", rsp_we, e.we);
                    if (!e.we) begin
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        last_rd = e.rdata;
                    end else begin
                        chk("rdata_held_on_write", rsp_rdata, last_rd);
                    end
                    chk("rsp_latency", 128'(cyc - e.acc), 128'd3);
                    chk("ce_pulses", 128'(ce_cnt), 128'd1);
                end
                ce_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int bank, input logic [8:0] row,
                          input logic hold, output int acc);
        logic [127:0] m;
        exp_t e;
        int n;
        m = '1;
        m[bank] = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_within_bound", 128'(n < 50), 128'd1);
        @(posedge CLK); #1;
        if (!hold) req_valid = 1'b0;
        acc = cyc;
        e.we = we; e.rdata = exp_rd; e.acc = cyc;
        sbq.push_back(e);
        if (we) ref_mem[a] = wd;
        chk("setup_addr", mem_addr, row);
        chk("setup_csb", mem_csb, m);
        chk("setup_web", mem_web, !we);
        chk("setup_ce", mem_ce, 1'b0);
        chk("setup_oeb", mem_oeb, {128{1'b1}});
        if (we) chk("setup_idata", mem_idata, wd);
        @(posedge CLK); #1;
        chk("strobe_ce", mem_ce, 1'b1);
        chk("strobe_csb", mem_csb, m);
        chk("strobe_oeb", mem_oeb, we ? {128{1'b1}} : m);
        chk("ready_low_busy", req_ready, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_responses", 128'(sbq.size()), 128'd0);
    endtask

    typedef struct {
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         bank;
        logic [8:0] row;
    } vec_t;
    vec_t vec[12];

    initial begin
        int acc, prev_acc, n, oeb_cnt, rsp_n;
        logic [7:0] rd3;
        logic       rwe3;
        logic [15:0] ba;

        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
        vec[0]  = '{1'b1, 16'h1234, 8'hA5, 8'h00, 9,   9'h034};
        vec[1]  = '{1'b0, 16'h1234, 8'h00, 8'hA5, 9,   9'h034};
        vec[2]  = '{1'b1, 16'h01FF, 8'h11, 8'h00, 0,   9'h1FF};
        vec[3]  = '{1'b1, 16'h0200, 8'h22, 8'h00, 1,   9'h000};
        vec[4]  = '{1'b0, 16'h01FF, 8'h00, 8'h11, 0,   9'h1FF};
        vec[5]  = '{1'b0, 16'h0200, 8'h00, 8'h22, 1,   9'h000};
        vec[6]  = '{1'b1, 16'hFFFF, 8'h3C, 8'h00, 127, 9'h1FF};
        vec[7]  = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 127, 9'h1FF};
        vec[8]  = '{1'b0, 16'h4321, 8'h00, pat(16'h4321), 33, 9'h121};
        vec[9]  = '{1'b1, 16'h0000, 8'h99, 8'h00, 0,   9'h000};
        vec[10] = '{1'b0, 16'h0000, 8'h00, 8'h99, 0,   9'h000};
        vec[11] = '{1'b1, 16'h5555, 8'h7E, 8'h00, 42,  9'h155};

        RST = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'hEE;
        req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_csb", mem_csb, {128{1'b1}});
        chk("rst_oeb", mem_oeb, {128{1'b1}});
        chk("rst_web", mem_web, 1'b1);
        chk("rst_ce", mem_ce, 1'b0);
        chk("rst_addr", mem_addr, 9'h0);
        chk("rst_idata", mem_idata, 8'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_we", rsp_we, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h0);
        req_valid = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ready", req_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            do_req(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].exp_rd, vec[i].bank, vec[i].row, 1'b0, acc);
            drain();
        end

        // REQ_VALID held high across alternating write/read pairs.
        prev_acc = 0;
        for (int k = 0; k < 6; k++) begin
            ba = 16'h2A00 + 16'((k / 2) * 513);
            do_req((k % 2) == 0, ba, 8'(8'hC0 + k), (k % 2) == 0 ? 8'h00 : ref_mem[ba],
                   int'(ba[15:9]), ba[8:0], 1'b1, acc);
            if (k > 0) chk("burst_spacing", 128'(acc - prev_acc), 128'd5);
            prev_acc = acc;
        end
        req_valid = 1'b0;
        drain();

        // Reset during the STROBE cycle of a read.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chk("abort_strobe_ce", mem_ce, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("abort_csb", mem_csb, {128{1'b1}});
        chk("abort_oeb", mem_oeb, {128{1'b1}});
        chk("abort_ce", mem_ce, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk("abort_no_rsp", rsp_valid, 1'b0);
        end
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 9, 9'h034, 1'b0, acc);
        drain();

        // RD_WAIT=3 instance reads the byte written earlier at 0x5555.
        @(negedge CLK);
        chk("d3_ready", req_ready3, 1'b1);
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'h5555;
        @(posedge CLK); #1;
        req_valid3 = 1'b0;
        oeb_cnt = 0; rsp_n = 0; rd3 = 8'h00; rwe3 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (mem_oeb3 != {128{1'b1}}) oeb_cnt++;
            if (rsp_valid3 && rsp_n == 0) begin
                rsp_n = c;
                rd3   = rsp_rdata3;
                rwe3  = rsp_we3;
            end
            @(posedge CLK); #1;
        end
        chk("d3_oeb_cycles", 128'(oeb_cnt), 128'd4);
        chk("d3_rsp_cycle", 128'(rsp_n), 128'd6);
        chk("d3_rdata", rd3, 8'h7E);
        chk("d3_rsp_we", rwe3, 1'b0);

        repeat (3) @(negedge CLK);
        chk("final_queue_empty", 128'(sbq.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
